audio_bram_arbiter: RTL

AUDIO_BRAM_ARBITER -- requirements
Module: audio_bram_arbiter

---
 rtl/audio_bram_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/audio_bram_arbiter.sv
// ============================================================================
// Module   : audio_bram_arbiter
// Purpose  : Arbitrates playback reads and host accesses onto a single BRAM
//            port with bounded host starvation. Optional ARB_STATS_EN adds
//            grant statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_bram_arbiter #(
    parameter int MEM_WORDS    = 30000,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pb_req,
    input  logic [31:0] pb_addr,
    output logic        pb_gnt,
    output logic        pb_rvalid,
    output logic [31:0] pb_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    output logic        host_err,
    output logic [31:0] bram_addr,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_din,
    input  logic [31:0] bram_dout
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] stat_pb_cnt,
    output logic [15:0] stat_host_cnt,
    output logic [15:0] stat_force_cnt
`endif
);

    localparam int                    c_starve_w   = $clog2(STARVE_LIMIT + 1);
    localparam logic [31:0]           c_mem_words  = 32'(MEM_WORDS);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);
    localparam logic [c_starve_w-1:0] c_starve_one = c_starve_w'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PB_ACC   = 2'd1,
        HOST_ACC = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [29:0]             r_addr;
    logic [29:0]             w_addr_nxt;
    logic                    r_we;
    logic                    w_we_nxt;
    logic [31:0]             r_wdata;
    logic [31:0]             w_wdata_nxt;
    logic [c_starve_w-1:0]   r_starve;
    logic [c_starve_w-1:0]   w_starve_nxt;
    logic                    w_host_ok;
    logic                    w_host_bad;
    logic                    w_starved;
    logic                    w_force;
    logic                    r_pb_rvalid;
    logic                    r_host_rvalid;
    logic                    r_host_err;
    logic [31:0]             r_pb_hold;
    logic [31:0]             r_host_hold;

    always_comb begin
        w_host_ok    = host_req && (host_addr < c_mem_words);
        w_host_bad   = host_req && !(host_addr < c_mem_words);
        w_starved    = (r_starve == c_starve_max);
        w_force      = pb_req && w_host_ok && w_starved;
        w_state_nxt  = IDLE;
        w_addr_nxt   = r_addr;
        w_we_nxt     = 1'b0;
        w_wdata_nxt  = r_wdata;
        w_starve_nxt = r_starve;

        if (w_force || (w_host_ok && !pb_req)) begin
            w_state_nxt = HOST_ACC;
            w_addr_nxt  = host_addr[29:0];
            w_we_nxt    = host_we;
            w_wdata_nxt = host_wdata;
        end else if (pb_req) begin
            w_state_nxt = PB_ACC;
            // Out-of-range playback indices wrap to the start of the buffer.
            w_addr_nxt  = (pb_addr < c_mem_words) ? pb_addr[29:0] : 30'd0;
        end

        if (!w_host_ok || (w_state_nxt == HOST_ACC)) begin
            w_starve_nxt = '0;
        end else if (!w_starved) begin
            w_starve_nxt = r_starve + c_starve_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_starve      <= '0;
            r_pb_rvalid   <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_host_err    <= 1'b0;
            r_pb_hold     <= '0;
            r_host_hold   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_we          <= w_we_nxt;
            r_wdata       <= w_wdata_nxt;
            r_starve      <= w_starve_nxt;
            r_pb_rvalid   <= (r_state == PB_ACC);
            r_host_rvalid <= (r_state == HOST_ACC) && !r_we;
            r_host_err    <= w_host_bad;
            if (r_pb_rvalid) begin
                r_pb_hold <= bram_dout;
            end
            if (r_host_rvalid) begin
                r_host_hold <= bram_dout;
            end
        end
    end

    // Read data is passed straight through on the rvalid cycle, then held.
    assign pb_gnt      = (r_state == PB_ACC);
    assign host_gnt    = (r_state == HOST_ACC);
    assign bram_en     = (r_state != IDLE);
    assign bram_addr   = bram_en ? {r_addr, 2'b00} : 32'd0;
    assign bram_we     = (host_gnt && r_we) ? 4'hF : 4'h0;
    assign bram_din    = (host_gnt && r_we) ? r_wdata : 32'd0;
    assign pb_rvalid   = r_pb_rvalid;
    assign host_rvalid = r_host_rvalid;
    assign pb_rdata    = r_pb_rvalid ? bram_dout : r_pb_hold;
    assign host_rdata  = r_host_rvalid ? bram_dout : r_host_hold;
    assign host_err    = r_host_err;

`ifdef ARB_STATS_EN
    logic        r_forced;
    logic [15:0] r_stat_pb;
    logic [15:0] r_stat_host;
    logic [15:0] r_stat_force;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_forced     <= 1'b0;
            r_stat_pb    <= '0;
            r_stat_host  <= '0;
            r_stat_force <= '0;
        end else begin
            r_forced <= w_force;
            if (pb_gnt) begin
                r_stat_pb <= r_stat_pb + 16'd1;
            end
            if (host_gnt) begin
                r_stat_host <= r_stat_host + 16'd1;
            end
            if (host_gnt && r_forced) begin
                r_stat_force <= r_stat_force + 16'd1;
            end
        end
    end

    assign stat_pb_cnt    = r_stat_pb;
    assign stat_host_cnt  = r_stat_host;
    assign stat_force_cnt = r_stat_force;
`endif

endmodule

`default_nettype wire
